pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
//  Sits directly downstream of the core PLL wrapper on the 74.25 MHz reference clock.
//  Drives the PLL's active-high rst and consumes its asynchronous locked output.
//  Waits for lock with a timeout-and-retry policy, debounces lock, then releases the core reset.
//  Re-runs the sequence on loss of lock and flags a sticky failure after repeated timeouts.
// PARAMETERS
//  RST_PULSE     64       cycles pll_rst is held high per PLL reset attempt (>=1)
//  LOCK_TIMEOUT  7425000  cycles allowed in WAIT_LOCK before a retry (100 ms @ 74.25 MHz)
//  SETTLE_CYCLES 4096     consecutive synced-lock cycles required before core release (>=1)
//  MAX_RETRIES   7        timeouts tolerated before FAIL (<=7, fits retry_count)
// PORTS
//  clk_74a        in   1  74.25 MHz reference clock (same net as the PLL refclk)
//  reset_n        in   1  asynchronous, active-low reset
//  pll_locked     in   1  PLL locked output; asynchronous to clk_74a
//  pll_rst        out  1  active-high reset to the PLL
//  core_reset_n   out  1  active-low reset to the core clock domains
//  locked_stable  out  1  high only in RUN
//  retry_count    out  3  number of lock timeouts since the last reset_n or the last RUN exit
//  fail           out  1  sticky: the retry budget is exhausted
// BEHAVIOUR
//  - Async reset (reset_n=0): state=RESET_PLL, cnt=0, sync flops=0, pll_rst=1, core_reset_n=0,
//    locked_stable=0, retry_count=0, fail=0. All outputs are registered.
//  - pll_locked passes through a 2-flop synchronizer to give lk. Flops reset to 0.
//  - cnt is a single shared counter, width $clog2(max(RST_PULSE,LOCK_TIMEOUT,SETTLE_CYCLES)+1).
//    It is cleared on every state change.
//  - RESET_PLL: pll_rst=1. After RST_PULSE cycles in this state -> WAIT_LOCK.
//    pll_rst is therefore high for exactly RST_PULSE cycles per entry.
//  - WAIT_LOCK: pll_rst=0, cnt increments.
//    - lk=1 -> SETTLE.
//    - else at cnt==LOCK_TIMEOUT-1:
//      - retry_count==MAX_RETRIES -> FAIL.
//      - otherwise retry_count+=1 and -> RESET_PLL.
//    - If lk rises on the timeout cycle, lock wins (-> SETTLE).
//  - SETTLE: cnt increments while lk=1.
//    - lk=0 -> WAIT_LOCK with a fresh timeout; no retry is charged.
//    - After SETTLE_CYCLES consecutive lk=1 cycles -> RUN.
//  - RUN: core_reset_n=1 and locked_stable=1, both asserted on the first RUN cycle.
//    - lk=0 -> RESET_PLL. core_reset_n=0 and locked_stable=0 on the next cycle.
//      retry_count is cleared.
//  - FAIL: pll_rst=0, core_reset_n=0, fail=1, retry_count holds.
//    Lock activity is ignored. Exit only via reset_n.
//  - Latency: pll_locked rise -> SETTLE entry in 3 cycles (2 sync + 1 state register).
//    From that rise -> core_reset_n=1 takes 3+SETTLE_CYCLES cycles.
//    Lock loss in RUN -> core_reset_n=0 takes 3 cycles.
//  - Glitches shorter than one cycle may be missed by the synchronizer; this is acceptable.
//    Any lk=0 sample restarts SETTLE.
//  - reset_n asserted mid-sequence (any state) forces the reset values immediately.
//    The sequence restarts from RESET_PLL.
// TESTING (bench uses RST_PULSE=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, MAX_RETRIES=2)
//  1 Clean start: release reset_n; raise pll_locked 5 cycles after pll_rst falls ->
//    pll_rst high exactly 4 cycles; core_reset_n rises 11 cycles after pll_locked;
//    retry_count=0.
//  2 Timeout retry: hold pll_locked=0 for 20 WAIT_LOCK cycles ->
//    retry_count=1 and pll_rst pulses 4 cycles; lock on the next attempt reaches RUN
//    with retry_count=1.
//  3 Exhaustion: pll_locked never rises -> three 4-cycle pll_rst pulses;
//    fail=1 after the 3rd timeout; retry_count=2; a later pll_locked=1 keeps core_reset_n=0.
//  4 Settle bounce: lock for 5 cycles, drop 1 cycle, relock ->
//    no retry charged; core_reset_n rises 11 cycles after the relock.
//  5 Lock loss in RUN: drop pll_locked -> core_reset_n=0 and locked_stable=0 3 cycles later;
//    pll_rst pulses 4 cycles; retry_count=0.
//  6 Reset mid-SETTLE and mid-FAIL: assert reset_n -> all outputs return to reset values
//    asynchronously; fail clears.

Source files
------------

// File: rtl/pll_lock_sequencer_if.sv
// Purpose: bundles the PLL-facing and core-facing signals of the lock sequencer.
// Latency: none; wires only.
// Backpressure: none; every signal is a level, with no handshake.
//
// Ports (master = sequencer side):
//   pll_locked     in   PLL locked output, asynchronous to clk_74a
//   pll_rst        out  active-high reset to the PLL
//   core_reset_n   out  active-low reset to the core clock domains
//   locked_stable  out  high only while the core is running on a stable lock
//   retry_count    out  lock timeouts since reset_n or the last RUN exit
//   fail           out  sticky: retry budget exhausted
interface pll_lock_sequencer_if;
   logic       pll_locked;
   logic       pll_rst;
   logic       core_reset_n;
   logic       locked_stable;
   logic [2:0] retry_count;
   logic       fail;

   modport master (
      input  pll_locked,
      output pll_rst,
      output core_reset_n,
      output locked_stable,
      output retry_count,
      output fail
   );

   modport slave (
      output pll_locked,
      input  pll_rst,
      input  core_reset_n,
      input  locked_stable,
      input  retry_count,
      input  fail
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Purpose: resets the PLL, waits for lock with timeout and retry, debounces lock, then releases the core reset.
// Latency: pll_locked rise -> SETTLE in 3 cycles, core_reset_n high after 3+SETTLE_CYCLES; lock loss -> core_reset_n low in 3.
// Backpressure: none; free-running control block whose outputs are registered levels.
//
// Ports:
//   clk_74a   in   74.25 MHz reference clock (same net as the PLL refclk)
//   reset_n   in   asynchronous, active-low reset
//   bus       pll_lock_sequencer_if.master: pll_locked in; pll_rst, core_reset_n,
//             locked_stable, retry_count and fail out
module pll_lock_sequencer #(
   parameter int RST_PULSE     = 64,
   parameter int LOCK_TIMEOUT  = 7425000,
   parameter int SETTLE_CYCLES = 4096,
   parameter int MAX_RETRIES   = 7
) (
   input  logic                  clk_74a,
   input  logic                  reset_n,
   pll_lock_sequencer_if.master  bus
);

   // One counter serves every timed state, so it must be sized for the longest interval.
   localparam int MAX_AB = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
   localparam int MAX_N  = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
   localparam int CW     = $clog2(MAX_N + 1);

   localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);
   localparam logic [2:0]    RETRY_MAX    = 3'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_RESET_PLL = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_SETTLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   state_t        state_q,         state_d;
   logic [CW-1:0] cnt_q,           cnt_d;
   logic          sync_meta_q,     sync_meta_d;
   logic          lk_q,            lk_d;
   logic [2:0]    retry_q,         retry_d;
   logic          pll_rst_q,       pll_rst_d;
   logic          core_reset_n_q,  core_reset_n_d;
   logic          locked_stable_q, locked_stable_d;
   logic          fail_q,          fail_d;

   // -------------------------------------------------------------------------
   // Two-flop synchronizer for the asynchronous PLL lock indication.
   // -------------------------------------------------------------------------
   always_comb begin
      sync_meta_d = bus.pll_locked;
      lk_d        = sync_meta_q;
   end

   // -------------------------------------------------------------------------
   // Next-state, counter and output logic.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_ONE;
      retry_d = retry_q;

      case (state_q)
         ST_RESET_PLL: begin
            if (cnt_q == RST_LAST) begin
               state_d = ST_WAIT_LOCK;
            end
         end

         ST_WAIT_LOCK: begin
            // Lock is checked first, so a lock arriving on the timeout cycle wins.
            if (lk_q) begin
               state_d = ST_SETTLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               if (retry_q == RETRY_MAX) begin
                  state_d = ST_FAIL;
               end else begin
                  retry_d = retry_q + 3'd1;
                  state_d = ST_RESET_PLL;
               end
            end
         end

         ST_SETTLE: begin
            // A single low sample aborts the debounce; the PLL is not reset for it.
            if (!lk_q) begin
               state_d = ST_WAIT_LOCK;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            cnt_d = cnt_q;
            if (!lk_q) begin
               state_d = ST_RESET_PLL;
               retry_d = 3'd0;
            end
         end

         ST_FAIL: begin
            cnt_d = cnt_q;
         end

         default: begin
            state_d = ST_RESET_PLL;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end

      // Outputs are registered from the next state so they change on the same
      // edge that enters the state.
      pll_rst_d       = (state_d == ST_RESET_PLL);
      core_reset_n_d  = (state_d == ST_RUN);
      locked_stable_d = (state_d == ST_RUN);
      fail_d          = (state_d == ST_FAIL);
   end

   // -------------------------------------------------------------------------
   // State and output registers.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_RESET_PLL;
         cnt_q           <= '0;
         sync_meta_q     <= 1'b0;
         lk_q            <= 1'b0;
         retry_q         <= 3'd0;
         pll_rst_q       <= 1'b1;
         core_reset_n_q  <= 1'b0;
         locked_stable_q <= 1'b0;
         fail_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         sync_meta_q     <= sync_meta_d;
         lk_q            <= lk_d;
         retry_q         <= retry_d;
         pll_rst_q       <= pll_rst_d;
         core_reset_n_q  <= core_reset_n_d;
         locked_stable_q <= locked_stable_d;
         fail_q          <= fail_d;
      end
   end

   assign bus.pll_rst       = pll_rst_q;
   assign bus.core_reset_n  = core_reset_n_q;
   assign bus.locked_stable = locked_stable_q;
   assign bus.retry_count   = retry_q;
   assign bus.fail          = fail_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Purpose: self-checking bench for pll_lock_sequencer with directed scenarios and random lock traffic.
// Latency: outputs are sampled on the falling edge, half a cycle after each active edge.
// Backpressure: none.
module tb_pll_lock_sequencer;
   localparam int RST_PULSE     = 4;
   localparam int LOCK_TIMEOUT  = 20;
   localparam int SETTLE_CYCLES = 8;
   localparam int MAX_RETRIES   = 2;

   // Reference-model phases.
   localparam int M_PULSE  = 0;
   localparam int M_WAIT   = 1;
   localparam int M_SETTLE = 2;
   localparam int M_RUN    = 3;
   localparam int M_FAILED = 4;

   logic clk_74a = 1'b0;
   logic reset_n;

   pll_lock_sequencer_if bus();

   pll_lock_sequencer #(
      .RST_PULSE     (RST_PULSE),
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .MAX_RETRIES   (MAX_RETRIES)
   ) dut (
      .clk_74a (clk_74a),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk_74a = ~clk_74a;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: elapsed-cycle accounting per phase plus a 2-deep lock pipeline.
   int m_mode;
   int m_age;
   int m_retries;
   bit m_s1;
   bit m_s2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_mode    = M_PULSE;
      m_age     = 0;
      m_retries = 0;
      m_s1      = 1'b0;
      m_s2      = 1'b0;
   endtask

   task automatic model_step(input bit locked);
      bit lk;
      lk   = m_s2;
      m_s2 = m_s1;
      m_s1 = locked;
      case (m_mode)
         M_PULSE: begin
            m_age++;
            if (m_age == RST_PULSE) begin
               m_mode = M_WAIT;
               m_age  = 0;
            end
         end
         M_WAIT: begin
            if (lk) begin
               m_mode = M_SETTLE;
               m_age  = 0;
            end else begin
               m_age++;
               if (m_age == LOCK_TIMEOUT) begin
                  m_age = 0;
                  if (m_retries == MAX_RETRIES) begin
                     m_mode = M_FAILED;
                  end else begin
                     m_retries++;
                     m_mode = M_PULSE;
                  end
               end
            end
         end
         M_SETTLE: begin
            if (!lk) begin
               m_mode = M_WAIT;
               m_age  = 0;
            end else begin
               m_age++;
               if (m_age == SETTLE_CYCLES) begin
                  m_mode = M_RUN;
                  m_age  = 0;
               end
            end
         end
         M_RUN: begin
            if (!lk) begin
               m_mode    = M_PULSE;
               m_age     = 0;
               m_retries = 0;
            end
         end
         default: begin
         end
      endcase
   endtask

   task automatic check_all();
      chk("model_pll_rst",       32'(bus.pll_rst),       32'(m_mode == M_PULSE));
      chk("model_core_reset_n",  32'(bus.core_reset_n),  32'(m_mode == M_RUN));
      chk("model_locked_stable", 32'(bus.locked_stable), 32'(m_mode == M_RUN));
      chk("model_fail",          32'(bus.fail),          32'(m_mode == M_FAILED));
      chk("model_retry_count",   32'(bus.retry_count),   32'(m_retries));
   endtask

   // One clock: step the model on the active edge, compare on the falling edge.
   task automatic cyc();
      @(posedge clk_74a);
      if (reset_n) model_step(bus.pll_locked);
      @(negedge clk_74a);
      check_all();
   endtask

   task automatic count_rst(input logic lvl, output int n);
      n = 0;
      while (bus.pll_rst === lvl && n < 200) begin
         cyc();
         n++;
      end
   endtask

   // Cycles spent waiting for lock before the next pll_rst pulse or fail.
   task automatic count_wait(output int n);
      n = 0;
      while (bus.pll_rst === 1'b0 && bus.fail === 1'b0 && n < 200) begin
         cyc();
         n++;
      end
   endtask

   task automatic count_core(input logic lvl, output int n);
      n = 0;
      while (bus.core_reset_n === lvl && n < 200) begin
         cyc();
         n++;
      end
   endtask

   // Asserts reset_n mid-cycle and checks that outputs change without a clock edge.
   task automatic hit_reset(input string tag);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      chk({tag, "_pll_rst"},       32'(bus.pll_rst),       32'(1));
      chk({tag, "_core_reset_n"},  32'(bus.core_reset_n),  32'(0));
      chk({tag, "_locked_stable"}, 32'(bus.locked_stable), 32'(0));
      chk({tag, "_retry_count"},   32'(bus.retry_count),   32'(0));
      chk({tag, "_fail"},          32'(bus.fail),          32'(0));
      @(negedge clk_74a);
      @(negedge clk_74a);
      reset_n = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      bit lvl;
      int hold;

      reset_n        = 1'b0;
      bus.pll_locked = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_74a);

      // Reset state.
      chk("reset_pll_rst",       32'(bus.pll_rst),       32'(1));
      chk("reset_core_reset_n",  32'(bus.core_reset_n),  32'(0));
      chk("reset_locked_stable", 32'(bus.locked_stable), 32'(0));
      chk("reset_retry_count",   32'(bus.retry_count),   32'(0));
      chk("reset_fail",          32'(bus.fail),          32'(0));
      reset_n = 1'b1;

      // Clean start.
      count_rst(1'b1, n);
      chk("t1_rst_pulse_len", 32'(n), 32'(RST_PULSE));
      repeat (5) cyc();
      bus.pll_locked = 1'b1;
      count_core(1'b0, n);
      chk("t1_lock_to_core", 32'(n), 32'(3 + SETTLE_CYCLES));
      chk("t1_retry_count", 32'(bus.retry_count), 32'(0));
      chk("t1_locked_stable", 32'(bus.locked_stable), 32'(1));

      // Lock loss in RUN.
      bus.pll_locked = 1'b0;
      count_core(1'b1, n);
      chk("t5_loss_to_core", 32'(n), 32'(3));
      chk("t5_locked_stable", 32'(bus.locked_stable), 32'(0));
      count_rst(1'b1, n);
      chk("t5_rst_pulse_len", 32'(n), 32'(RST_PULSE));
      chk("t5_retry_count", 32'(bus.retry_count), 32'(0));

      // Timeout retry.
      count_wait(n);
      chk("t2_timeout_len", 32'(n), 32'(LOCK_TIMEOUT));
      chk("t2_retry_count", 32'(bus.retry_count), 32'(1));
      count_rst(1'b1, n);
      chk("t2_rst_pulse_len", 32'(n), 32'(RST_PULSE));
      bus.pll_locked = 1'b1;
      count_core(1'b0, n);
      chk("t2_lock_to_core", 32'(n), 32'(3 + SETTLE_CYCLES));
      chk("t2_retry_in_run", 32'(bus.retry_count), 32'(1));

      // Settle bounce: leave RUN first, which also clears the retry count.
      bus.pll_locked = 1'b0;
      count_core(1'b1, n);
      count_rst(1'b1, n);
      chk("t4_retry_cleared", 32'(bus.retry_count), 32'(0));
      bus.pll_locked = 1'b1;
      repeat (5) cyc();
      bus.pll_locked = 1'b0;
      cyc();
      bus.pll_locked = 1'b1;
      count_core(1'b0, n);
      chk("t4_relock_to_core", 32'(n), 32'(3 + SETTLE_CYCLES));
      chk("t4_retry_count", 32'(bus.retry_count), 32'(0));

      // Reset mid-SETTLE.
      bus.pll_locked = 1'b0;
      count_core(1'b1, n);
      count_rst(1'b1, n);
      bus.pll_locked = 1'b1;
      repeat (6) cyc();
      chk("t6_settle_core_low", 32'(bus.core_reset_n), 32'(0));
      bus.pll_locked = 1'b0;
      hit_reset("t6_settle");

      // Exhaustion: three pulses, three timeouts, then FAIL.
      for (int a = 0; a < 3; a++) begin
         count_rst(1'b1, n);
         chk("t3_rst_pulse_len", 32'(n), 32'(RST_PULSE));
         count_wait(n);
         chk("t3_timeout_len", 32'(n), 32'(LOCK_TIMEOUT));
      end
      chk("t3_fail", 32'(bus.fail), 32'(1));
      chk("t3_retry_count", 32'(bus.retry_count), 32'(MAX_RETRIES));
      chk("t3_pll_rst_low", 32'(bus.pll_rst), 32'(0));
      bus.pll_locked = 1'b1;
      repeat (30) cyc();
      chk("t3_core_held", 32'(bus.core_reset_n), 32'(0));
      chk("t3_fail_sticky", 32'(bus.fail), 32'(1));

      // Reset mid-FAIL.
      hit_reset("t6_fail");

      // Random lock traffic against the reference model.
      lvl  = 1'b0;
      hold = 0;
      bus.pll_locked = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            lvl  = ~lvl;
            hold = lvl ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 26));
            bus.pll_locked = lvl;
         end
         hold--;
         if ($urandom_range(0, 199) == 0) begin
            hit_reset("rnd_reset");
         end else begin
            cyc();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
